if_id_buffer: RTL

IF_ID_BUFFER -- requirements
Module: if_id_buffer

---
 rtl/if_id_buffer.sv | 96 +++++++++
 1 files changed

// File: rtl/if_id_buffer.sv
// IF/ID pipeline buffer: a small circular FIFO of {pc, inst} fetch entries
// between fetch and decode. Presents NOP_INST to decode whenever it is empty.
module if_id_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter logic [31:0] NOP_INST = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wp_q, wp_d;
  logic [PtrW-1:0] rp_q, rp_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic push;
  logic pop;

  // Handshake status comes from state only; no full-buffer pass-through.
  always_comb begin
    in_ready  = (cnt_q < CntW'(DEPTH));
    out_valid = (cnt_q != '0);
    push      = in_valid && in_ready && !flush;
    pop       = out_valid && out_ready && !flush;
  end

  // Head entry to decode; storage is never exposed while empty.
  always_comb begin
    if (out_valid) begin
      out_pc   = pc_mem[rp_q];
      out_inst = inst_mem[rp_q];
    end else begin
      out_pc   = '0;
      out_inst = NOP_INST;
    end
    count = cnt_q;
  end

  // Pointer/occupancy next state; flush overrides any push or pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      // DEPTH is a power of two, so natural overflow gives the modulo wrap.
      if (push) wp_d = wp_q + 1'b1;
      if (pop)  rp_d = rp_q + 1'b1;
      if (push && !pop) begin
        cnt_d = cnt_q + CntW'(1);
      end else if (pop && !push) begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written at the write pointer on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wp_q]   <= in_pc;
      inst_mem[wp_q] <= in_inst;
    end
  end

endmodule
